mux_scan: RTL and testbench

Channel-scan sequencer that drives the select and enable of the 4:1 bit multiplexer stage and captures its output. On a start request it steps `S` through every channel set in a 4-bit mask. It holds each channel for a programmable dwell time and samples the mux output at the end of each dwell. Once all masked channels are sampled it presents the assembled 4-bit word with a one-cycle valid pulse to downstream logic.

---
 rtl/mux_scan.sv | 179 +++++++++++++++++
 tb/tb_mux_scan.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: channel-scan sequencer for a 4:1 bit multiplexer stage.
// Steps the mux select through every channel set in a latched mask, holds
// each channel for DWELL cycles, samples the mux output at the end of each
// dwell and presents the assembled word with a one-cycle valid pulse.
//
// Ports:
//   clk       - clock, all state on rising edge
//   rst_n     - asynchronous active-low reset
//   start_i   - scan request, level-sampled in IDLE
//   stop_i    - abort request, sampled in SCAN and DONE
//   cont_i    - continuous mode, restart after each completed scan
//   mask_i    - channel enable mask (bit i = channel i), latched at scan start
//   y_i       - mux stage output (combinational from s_o/en_o)
//   s_o       - channel select to the mux
//   en_o      - mux enable
//   data_o    - last completed scan word, 0 for unmasked channels
//   valid_o   - one-cycle pulse when data_o is updated
//   busy_o    - high while scanning or presenting a result
module mux_scan #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       stop_i,
   input  logic       cont_i,
   input  logic [3:0] mask_i,
   input  logic       y_i,
   output logic [1:0] s_o,
   output logic       en_o,
   output logic [3:0] data_o,
   output logic       valid_o,
   output logic       busy_o
);

   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       s_q, s_d;
   logic             en_q, en_d;
   logic [3:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       mask_q, mask_d;
   logic [3:0]       word_q, word_d;

   logic             nxt_found;
   logic [1:0]       nxt_ch;
   logic [1:0]       low_ch;
   logic [3:0]       word_merged;

   // Lowest set bit of the incoming mask: first channel of a new scan.
   always_comb begin
      low_ch = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_i[i]) low_ch = 2'(i);
      end
   end

   // Next higher set bit of the latched mask above the current channel.
   always_comb begin
      nxt_found = 1'b0;
      nxt_ch    = s_q;
      for (int i = 0; i < 4; i++) begin
         if (!nxt_found && mask_q[i] && (32'(i) > 32'(s_q))) begin
            nxt_found = 1'b1;
            nxt_ch    = 2'(i);
         end
      end
   end

   // Shadow word with the current channel's sample merged in.
   always_comb begin
      word_merged      = word_q;
      word_merged[s_q] = y_i;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      word_d  = word_q;
      data_d  = data_q;
      valid_d = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !stop_i && (mask_i != 4'd0)) begin
               state_d = ST_SCAN;
               mask_d  = mask_i;
               word_d  = 4'd0;
               s_d     = low_ch;
               cnt_d   = CNT_RELOAD;
            end
         end
         ST_SCAN: begin
            // Abort wins over a sample falling on the same edge.
            if (stop_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               word_d = word_merged;
               if (nxt_found) begin
                  s_d   = nxt_ch;
                  cnt_d = CNT_RELOAD;
               end else begin
                  data_d  = word_merged;
                  valid_d = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (cont_i && !stop_i && (mask_i != 4'd0)) begin
               state_d = ST_SCAN;
               mask_d  = mask_i;
               word_d  = 4'd0;
               s_d     = low_ch;
               cnt_d   = CNT_RELOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs follow the state being entered so they are registered.
      if (state_d == ST_IDLE) s_d = 2'd0;
      en_d   = (state_d == ST_SCAN);
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         s_q     <= 2'd0;
         en_q    <= 1'b0;
         data_q  <= 4'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mask_q  <= 4'd0;
         word_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         en_q    <= en_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         word_q  <= word_d;
      end
   end

   assign s_o     = s_q;
   assign en_o    = en_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_mux_scan.sv
// Testbench for mux_scan: a DWELL=4 instance and a DWELL=1 instance, each
// driving a behavioural 4:1 mux model. Expected scan words and latencies
// are queued when a scan is launched and popped when VALID is observed.
module tb_mux_scan;

   localparam int DW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, stop, cont, y;
   logic [3:0] mask, xpat, data;
   logic [1:0] s;
   logic       en, valid, busy;

   logic       start1, y1;
   logic [3:0] mask1, x1, data1;
   logic [1:0] s1;
   logic       en1, valid1, busy1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [3:0] exp_q[$];
   int         lat_q[$];

   // Mux stage models.
   assign y  = en  ? xpat[s] : 1'b0;
   assign y1 = en1 ? x1[s1]  : 1'b0;

   mux_scan #(.DWELL(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .stop_i  (stop),
      .cont_i  (cont),
      .mask_i  (mask),
      .y_i     (y),
      .s_o     (s),
      .en_o    (en),
      .data_o  (data),
      .valid_o (valid),
      .busy_o  (busy)
   );

   mux_scan #(.DWELL(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start1),
      .stop_i  (1'b0),
      .cont_i  (1'b0),
      .mask_i  (mask1),
      .y_i     (y1),
      .s_o     (s1),
      .en_o    (en1),
      .data_o  (data1),
      .valid_o (valid1),
      .busy_o  (busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; stop = 1'b0; cont = 1'b0; mask = 4'hF; xpat = 4'h0;
      start1 = 1'b1; mask1 = 4'h8; x1 = 4'h0;
      repeat (3) tick();
      total++; if (s !== 2'd0)     begin bad++; $display("FAIL reset_s got=%0d exp=0", s); end
      total++; if (en !== 1'b0)    begin bad++; $display("FAIL reset_en got=%0b exp=0", en); end
      total++; if (data !== 4'h0)  begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", valid); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      total++; if (busy1 !== 1'b0 || en1 !== 1'b0) begin
         bad++; $display("FAIL reset_dut1 got busy=%0b en=%0b exp 0 0", busy1, en1);
      end
      start = 1'b0; start1 = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%0b exp=0", busy); end
   endtask

   task automatic do_scan(input string name, input logic [3:0] m, input logic [3:0] x);
      logic [1:0] chs[$];
      int         lat;
      int         nval;
      logic [3:0] exp_d;
      int         exp_l;
      for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(2'(i));
      lat = chs.size() * DW;
      mask = m; xpat = x; start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(m & x);
      lat_q.push_back(lat);
      nval = 0;
      for (int rel = 0; rel <= lat + 2; rel++) begin
         if (rel > 0) tick();
         if (rel < lat) begin
            total++;
            if (s !== chs[rel / DW] || en !== 1'b1) begin
               bad++;
               $display("FAIL %s_sel rel=%0d got s=%0d en=%0b exp s=%0d en=1", name, rel, s, en, chs[rel / DW]);
            end
         end
         if (valid === 1'b1) begin
            nval++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL %s_extra_valid rel=%0d got valid=1 exp none", name, rel);
            end else begin
               exp_d = exp_q.pop_front();
               exp_l = lat_q.pop_front();
               total++;
               if (data !== exp_d) begin bad++; $display("FAIL %s_data got=%b exp=%b", name, data, exp_d); end
               total++;
               if (rel != exp_l) begin bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, rel, exp_l); end
            end
         end
      end
      total++; if (nval != 1)     begin bad++; $display("FAIL %s_valid_count got=%0d exp=1", name, nval); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_end_busy got=%0b exp=0", name, busy); end
      exp_q.delete(); lat_q.delete();
   endtask

   task automatic test_full();
      do_scan("full", 4'hF, 4'b1010);
   endtask

   task automatic test_sparse();
      do_scan("sparse", 4'b0101, 4'b1111);
   endtask

   task automatic test_ignored();
      mask = 4'h0; start = 1'b1; stop = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin mask = 4'hF; stop = 1'b1; end
         tick();
         total++;
         if (busy !== 1'b0 || en !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL ignored k=%0d got busy=%0b en=%0b valid=%0b exp 0 0 0", k, busy, en, valid);
         end
      end
      start = 1'b0; stop = 1'b0;
      tick();
   endtask

   task automatic test_cont();
      int         nval;
      logic [3:0] exp_d;
      int         exp_l;
      cont = 1'b1; mask = 4'hF; xpat = 4'b0011; start = 1'b1;
      tick();
      start = 1'b0;
      exp_q.push_back(4'b0011); lat_q.push_back(16);
      exp_q.push_back(4'b1100); lat_q.push_back(33);
      nval = 0;
      for (int rel = 0; rel <= 46; rel++) begin
         if (rel > 0) tick();
         if (rel == 16) xpat = 4'b1100;
         if (rel == 17 || rel == 34) begin
            total++;
            if (en !== 1'b1 || s !== 2'd0) begin
               bad++; $display("FAIL cont_restart rel=%0d got en=%0b s=%0d exp en=1 s=0", rel, en, s);
            end
         end
         if (rel == 41) begin
            total++;
            if (busy !== 1'b0 || en !== 1'b0 || s !== 2'd0) begin
               bad++; $display("FAIL cont_stop got busy=%0b en=%0b s=%0d exp 0 0 0", busy, en, s);
            end
            stop = 1'b0; cont = 1'b0;
         end
         if (valid === 1'b1) begin
            nval++;
            total++;
            if (en !== 1'b0) begin bad++; $display("FAIL cont_gap_en rel=%0d got=%0b exp=0", rel, en); end
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL cont_extra_valid rel=%0d got valid=1 exp none", rel);
            end else begin
               exp_d = exp_q.pop_front();
               exp_l = lat_q.pop_front();
               total++;
               if (data !== exp_d) begin bad++; $display("FAIL cont_data got=%b exp=%b", data, exp_d); end
               total++;
               if (rel != exp_l) begin bad++; $display("FAIL cont_latency got=%0d exp=%0d", rel, exp_l); end
            end
         end
         if (rel == 40) stop = 1'b1;
      end
      total++; if (nval != 2)         begin bad++; $display("FAIL cont_valid_count got=%0d exp=2", nval); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cont_pending got=%0d exp=0", exp_q.size()); end
      total++; if (data !== 4'b1100)  begin bad++; $display("FAIL cont_data_held got=%b exp=1100", data); end
      exp_q.delete(); lat_q.delete();
   endtask

   task automatic test_dwell1();
      logic [3:0] exp_d;
      mask1 = 4'b1000; x1 = 4'b1000; start1 = 1'b1;
      tick();
      start1 = 1'b0; mask1 = 4'h1;
      exp_q.push_back(4'b1000); lat_q.push_back(1);
      total++;
      if (s1 !== 2'd3 || en1 !== 1'b1) begin
         bad++; $display("FAIL dwell1_sel got s=%0d en=%0b exp s=3 en=1", s1, en1);
      end
      tick();
      total++;
      if (valid1 !== 1'b1) begin
         bad++; $display("FAIL dwell1_valid got=%0b exp=1", valid1);
      end else begin
         exp_d = exp_q.pop_front();
         void'(lat_q.pop_front());
         total++;
         if (data1 !== exp_d) begin bad++; $display("FAIL dwell1_data got=%b exp=%b", data1, exp_d); end
      end
      total++;
      if (en1 !== 1'b0 || s1 !== 2'd3) begin
         bad++; $display("FAIL dwell1_done got en=%0b s=%0d exp en=0 s=3", en1, s1);
      end
      tick();
      total++;
      if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
         bad++; $display("FAIL dwell1_idle got valid=%0b busy=%0b exp 0 0", valid1, busy1);
      end
      exp_q.delete(); lat_q.delete();
   endtask

   task automatic test_reset_mid();
      int nv;
      mask = 4'hF; xpat = 4'hF; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      total++; if (s !== 2'd0)     begin bad++; $display("FAIL rmid_s got=%0d exp=0", s); end
      total++; if (en !== 1'b0)    begin bad++; $display("FAIL rmid_en got=%0b exp=0", en); end
      total++; if (data !== 4'h0)  begin bad++; $display("FAIL rmid_data got=%b exp=0000", data); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b exp=0", valid); end
      repeat (2) tick();
      rst_n = 1'b1;
      nv = 0;
      repeat (25) begin
         tick();
         if (valid === 1'b1) nv++;
      end
      total++; if (nv != 0) begin bad++; $display("FAIL rmid_no_valid got=%0d exp=0", nv); end
   endtask

   initial begin
      test_reset();
      test_full();
      test_sparse();
      test_ignored();
      test_cont();
      test_dwell1();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
